// File: rtl/learntc_fifo.sv
// Learnt-clause FIFO: buffers clauses from conflict analysis, tagging each with its
// literal count and bin id at push time, and drains them over a show-ahead valid/ready port.
module learntc_fifo #(
  parameter int NUM_VARS     = 8,
  parameter int DEPTH        = 4,
  parameter int WIDTH_C_LEN  = 4,
  parameter int WIDTH_BIN_ID = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      add_learntc_en_i,
  input  logic [NUM_VARS*2-1:0]     learnt_lit_i,
  input  logic [WIDTH_BIN_ID-1:0]   cur_bin_num_i,
  input  logic                      clear_i,
  output logic                      lc_valid_o,
  input  logic                      lc_ready_i,
  output logic [NUM_VARS*2-1:0]     lc_lits_o,
  output logic [WIDTH_C_LEN-1:0]    lc_len_o,
  output logic [WIDTH_BIN_ID-1:0]   lc_bin_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  output logic                      empty_learntc_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [NUM_VARS*2-1:0]   lits;
    logic [WIDTH_C_LEN-1:0]  len;
    logic [WIDTH_BIN_ID-1:0] bin;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic            r_empty_lc;

  logic [WIDTH_C_LEN-1:0] w_len;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_pop;
  entry_t                 w_head;

  // NOTE: default assignment first so every path drives w_len and no latch is inferred.
  always_comb begin
    w_len = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (learnt_lit_i[2*i +: 2] != 2'b00) w_len = w_len + WIDTH_C_LEN'(1);
    end
  end

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty & lc_ready_i & ~clear_i;
  assign w_push_req = add_learntc_en_i & (w_len != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop) & ~clear_i;

  // NOTE: the storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{lits: learnt_lit_i, len: w_len, bin: cur_bin_num_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_empty_lc <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_empty_lc <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      r_empty_lc <= add_learntc_en_i & (w_len == '0);
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign lc_valid_o      = ~w_empty;
  assign lc_lits_o       = w_head.lits;
  assign lc_len_o        = w_head.len;
  assign lc_bin_o        = w_head.bin;
  assign count_o         = r_count;
  assign full_o          = w_full;
  assign empty_o         = w_empty;
  assign overflow_o      = r_overflow;
  assign empty_learntc_o = r_empty_lc;

endmodule

// File: tb/tb_learntc_fifo.sv
// Self-checking bench for learntc_fifo: scoreboard queue model plus a table of
// per-cycle expectations and a few hand-written corner sequences.
module tb_learntc_fifo;

  localparam int NV    = 8;
  localparam int DEPTH = 4;
  localparam int WL    = 4;
  localparam int WB    = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            add_learntc_en_i = 1'b0;
  logic [NV*2-1:0] learnt_lit_i = '0;
  logic [WB-1:0]   cur_bin_num_i = '0;
  logic            clear_i = 1'b0;
  logic            lc_ready_i = 1'b0;
  logic            lc_valid_o;
  logic [NV*2-1:0] lc_lits_o;
  logic [WL-1:0]   lc_len_o;
  logic [WB-1:0]   lc_bin_o;
  logic [2:0]      count_o;
  logic            full_o, empty_o, overflow_o, empty_learntc_o;

  learntc_fifo #(.NUM_VARS(NV), .DEPTH(DEPTH), .WIDTH_C_LEN(WL), .WIDTH_BIN_ID(WB)) dut (
    .clk(clk), .rst(rst),
    .add_learntc_en_i(add_learntc_en_i), .learnt_lit_i(learnt_lit_i),
    .cur_bin_num_i(cur_bin_num_i), .clear_i(clear_i),
    .lc_valid_o(lc_valid_o), .lc_ready_i(lc_ready_i),
    .lc_lits_o(lc_lits_o), .lc_len_o(lc_len_o), .lc_bin_o(lc_bin_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .empty_learntc_o(empty_learntc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lits;
    logic [3:0]  len;
    logic [9:0]  bin;
  } ent_t;

  typedef struct {
    logic        en;
    logic [15:0] lits;
    logic [9:0]  bin;
    logic        rdy;
    logic        clr;
    int          exp_count;
    logic        exp_ovf;
    logic        exp_elc;
  } vec_t;

  ent_t sb[$];
  bit   m_ovf, m_elc;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] ref_len(input logic [15:0] l);
    int c = 0;
    for (int i = 0; i < 8; i++) if (l[2*i +: 2] != 2'b00) c++;
    return 4'(c);
  endfunction

  // Called at a negedge: drive one cycle of stimulus, check head, update model, check state.
  task automatic do_cycle(input logic en, input logic [15:0] lits, input logic [9:0] bin,
                          input logic clr, input logic rdy);
    logic pop, push_req;
    ent_t e;
    add_learntc_en_i = en;
    learnt_lit_i     = lits;
    cur_bin_num_i    = bin;
    clear_i          = clr;
    lc_ready_i       = rdy;
    #1;
    check("valid_pre", 32'(lc_valid_o), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("head_lits", 32'(lc_lits_o), 32'(sb[0].lits));
      check("head_len",  32'(lc_len_o),  32'(sb[0].len));
      check("head_bin",  32'(lc_bin_o),  32'(sb[0].bin));
    end
    pop      = (sb.size() != 0) && rdy;
    push_req = en && (ref_len(lits) != 4'd0);
    if (clr) begin
      sb.delete();
      m_ovf = 1'b0;
      m_elc = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push_req) begin
        if (sb.size() < DEPTH) begin
          e.lits = lits; e.len = ref_len(lits); e.bin = bin;
          sb.push_back(e);
        end else m_ovf = 1'b1;
      end
      m_elc = en && (ref_len(lits) == 4'd0);
    end
    @(negedge clk);
    check("count",    32'(count_o),         32'(sb.size()));
    check("full",     32'(full_o),          32'(sb.size() == DEPTH));
    check("empty",    32'(empty_o),         32'(sb.size() == 0));
    check("valid",    32'(lc_valid_o),      32'(sb.size() != 0));
    check("overflow", 32'(overflow_o),      32'(m_ovf));
    check("empty_lc", 32'(empty_learntc_o), 32'(m_elc));
  endtask

  initial begin
    //             en    lits      bin  rdy  clr  cnt ovf elc
    vecs[0]  = '{1'b1, 16'h4801, 10'd3,    1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 10'd0,    1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 10'd4,    1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 10'd0,    1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'hC000, 10'd7,    1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h5555, 10'd1023, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'hAAAA, 10'd5,    1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h0001, 10'd9,    1'b0, 1'b0, 4, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0002, 10'd10,   1'b1, 1'b0, 4, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h0004, 10'd11,   1'b0, 1'b0, 4, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 10'd0,    1'b1, 1'b0, 3, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 10'd0,    1'b1, 1'b0, 2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 10'd0,    1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 10'd0,    1'b1, 1'b0, 0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 10'd0,    1'b0, 1'b1, 0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full",  32'(full_o),  32'd0);
    check("rst_valid", 32'(lc_valid_o), 32'd0);
    check("rst_ovf",   32'(overflow_o), 32'd0);
    check("rst_elc",   32'(empty_learntc_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven sequence: basic push/pop, empty clause, fill, full push+pop, overflow, drain, clear
    for (int i = 0; i < 15; i++) begin
      do_cycle(vecs[i].en, vecs[i].lits, vecs[i].bin, vecs[i].clr, vecs[i].rdy);
      check($sformatf("tbl%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
      check($sformatf("tbl%0d_ovf", i),   32'(overflow_o), 32'(vecs[i].exp_ovf));
      check($sformatf("tbl%0d_elc", i),   32'(empty_learntc_o), 32'(vecs[i].exp_elc));
      if (i == 0) begin
        check("first_len", 32'(lc_len_o), 32'd3);
        check("first_bin", 32'(lc_bin_o), 32'd3);
      end
    end

    // Fill 3, then clear together with a push: push discarded, no flag
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 16'h0100 << (2*i), 10'(20 + i), 1'b0, 1'b0);
    do_cycle(1'b1, 16'h1111, 10'd99, 1'b1, 1'b1);
    check("clr_count", 32'(count_o), 32'd0);
    check("clr_empty", 32'(empty_o), 32'd1);
    check("clr_ovf",   32'(overflow_o), 32'd0);

    // Empty-clause strobe coincident with clear produces no pulse
    do_cycle(1'b1, 16'h0000, 10'd1, 1'b1, 1'b0);
    check("clr_elc", 32'(empty_learntc_o), 32'd0);

    // Pointer wrap: one primed entry, then 10 simultaneous push/pop pairs, then drain
    do_cycle(1'b1, 16'h8000, 10'd100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 16'($urandom_range(1, 16'hFFFF)), 10'(200 + i), 1'b0, 1'b1);
    check("wrap_count", 32'(count_o), 32'd1);
    do_cycle(1'b0, 16'h0000, 10'd0, 1'b0, 1'b1);
    check("wrap_drained", 32'(empty_o), 32'd1);

    // Asynchronous reset between edges with 2 entries queued
    do_cycle(1'b1, 16'h0009, 10'd300, 1'b0, 1'b0);
    do_cycle(1'b1, 16'h0090, 10'd301, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_valid", 32'(lc_valid_o), 32'd0);
    check("arst_empty", 32'(empty_o), 32'd1);
    check("arst_full",  32'(full_o), 32'd0);
    check("arst_ovf",   32'(overflow_o), 32'd0);
    check("arst_elc",   32'(empty_learntc_o), 32'd0);
    sb.delete();
    m_ovf = 1'b0;
    m_elc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_cycle(1'b1, 16'h0003, 10'd400, 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0000, 10'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
